// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module : sersub_pkg
// Brief  : Shared types and helpers for the serial subtractor block.
//          - state_t    : FSM state encoding (IDLE/RUN/DONE)
//          - calc_steps : number of clock steps for a WIDTH-bit subtract
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module : serial_subtractor_if
// Brief  : Handshake/data bundle for serial_subtractor.
//          Input side : in_valid, in_ready, a, b, bin
//          Output side: out_valid, out_ready, diff, bout, busy
//          Optional   : ovf (only when SERIAL_SUBTRACTOR_OVF_EN is defined)
//          master = operand producer / result consumer, slave = subtractor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_subtractor_fsub_cell.sv
// ============================================================================
// Module : fsub_cell
// Brief  : Purely combinational 1-bit full subtractor: d = a - b - bin.
//          Ports: a, b, bin (in) ; d, bout (out)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b > a, or when a == b and a borrow comes in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module : serial_subtractor
// Brief  : Multi-cycle unsigned subtractor, diff = a - b - bin over WIDTH bits,
//          BITS_PER_CYCLE bits per clock, LSB first, borrow kept in a register.
//          Ports: clk, rst_n (async, active-low), bus (serial_subtractor_if
//          slave: valid/ready in, valid/ready out, diff, bout, busy [, ovf]).
//          Optional macro SERIAL_SUBTRACTOR_OVF_EN adds signed-overflow flag ovf.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    generate
        if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH (WIDTH >= 1)");
        end
    endgenerate

    localparam int             STEPS     = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int             CNT_W     = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_b;
    logic [WIDTH-1:0]          r_diff;
    logic                      r_borrow;
    logic                      r_bout;
    logic                      r_init;
    logic [CNT_W-1:0]          r_cnt;
    logic [BITS_PER_CYCLE-1:0] w_d;
    logic [BITS_PER_CYCLE:0]   w_bc;
    logic [WIDTH-1:0]          w_diff_next;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic                      r_a_msb;
    logic                      r_b_msb;
    logic                      r_ovf;
`endif

    // ---------------------------------------------------------------- cells
    assign w_bc[0] = r_borrow;

    generate
        for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
            fsub_cell u_cell (
                .a    (r_a[i]),
                .b    (r_b[i]),
                .bin  (w_bc[i]),
                .d    (w_d[i]),
                .bout (w_bc[i+1])
            );
        end
    endgenerate

    // New digits enter at the MSB side, so after STEPS shifts the first
    // digit produced ends up at the LSB.
    generate
        if (STEPS == 1) begin : g_diff_single
            assign w_diff_next = w_d;
        end else begin : g_diff_shift
            assign w_diff_next = {w_d, r_diff[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    // r_init holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_init  <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = r_init;
                if (bus.in_valid && r_init) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && r_init && bus.in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_STEP);

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
`endif
        end else if (r_state == RUN) begin
            r_a      <= r_a >> BITS_PER_CYCLE;
            r_b      <= r_b >> BITS_PER_CYCLE;
            r_diff   <= w_diff_next;
            r_borrow <= w_bc[BITS_PER_CYCLE];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_bout <= w_bc[BITS_PER_CYCLE];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                // Operands of differing sign whose result sign differs from a.
                r_ovf  <= (r_a_msb != r_b_msb) && (w_diff_next[WIDTH-1] != r_a_msb);
`endif
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module : tb_serial_subtractor
// Brief  : Self-checking bench for serial_subtractor. Instantiates an 8-bit,
//          1-bit/cycle build and a 4-bit, 2-bit/cycle build. Directed vectors
//          with hand-computed results, backpressure, mid-run reset, and an
//          exhaustive 4-bit sweep against a 5-bit arithmetic model.
//          With SERIAL_SUBTRACTOR_OVF_EN defined the ovf flag is also checked.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one transaction on the 8-bit instance. With rdy=0 the task returns
    // with the result still held in DONE.
    task automatic txn8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vbin, input logic [7:0] ed, input logic eb,
                        input logic eovf, input logic rdy);
        int n;
        int lat;
        bit seen;
        if8.out_ready = rdy;
        n = 0;
        while (!if8.in_ready && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_in_ready"}, 32'(if8.in_ready), 32'd1);
        if8.in_valid = 1'b1;
        if8.a        = va;
        if8.b        = vb;
        if8.bin      = vbin;
        tick();
        if8.in_valid = 1'b0;
        if8.a        = ~va;
        if8.b        = ~vb;
        if8.bin      = ~vbin;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            seen = if8.out_valid;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd8);
        check_val({tag, "_diff"}, 32'(if8.diff), 32'(ed));
        check_val({tag, "_bout"}, 32'(if8.bout), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check_val({tag, "_ovf"}, 32'(if8.ovf), 32'(eovf));
`endif
        if (rdy) begin
            tick();
            check_val({tag, "_valid_drop"}, 32'(if8.out_valid), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0; if8.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0; if4.out_ready = 1'b1;

        // ---------------- reset values
        #12;
        check_val("rst_in_ready",  32'(if8.in_ready),  32'd0);
        check_val("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check_val("rst_diff",      32'(if8.diff),      32'd0);
        check_val("rst_bout",      32'(if8.bout),      32'd0);
        check_val("rst_busy",      32'(if8.busy),      32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check_val("rst_ovf",       32'(if8.ovf),       32'd0);
`endif
        #1;
        rst_n = 1'b1;
        #1;
        check_val("post_rst_in_ready_low", 32'(if8.in_ready), 32'd0);
        tick();
        check_val("post_rst_in_ready_high", 32'(if8.in_ready), 32'd1);
        check_val("post_rst_in_ready4",     32'(if4.in_ready), 32'd1);

        // ---------------- directed vectors (WIDTH=8, BPC=1)
        txn8("v05m03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        txn8("v00m01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
        txn8("vFFmFFb",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        txn8("v10m01b",  8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b1);
        txn8("v80m01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
        txn8("v7Fm01",   8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);

        // ---------------- backpressure: 0x3C - 0x5A = 0xE2 with borrow
        txn8("bp", 8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check_val("bp_diff_hold",  32'(if8.diff),      32'hE2);
            check_val("bp_bout_hold",  32'(if8.bout),      32'd1);
            check_val("bp_in_ready",   32'(if8.in_ready),  32'd0);
            check_val("bp_out_valid",  32'(if8.out_valid), 32'd1);
            if (k == 2) begin
                if8.in_valid = 1'b1;
                if8.a        = 8'h11;
                if8.b        = 8'h22;
            end
            tick();
            if8.in_valid = 1'b0;
        end
        if8.out_ready = 1'b1;
        tick();
        check_val("bp_release_valid",    32'(if8.out_valid), 32'd0);
        check_val("bp_release_in_ready", 32'(if8.in_ready),  32'd1);
        check_val("bp_release_busy",     32'(if8.busy),      32'd0);

        // ---------------- reset during RUN, then a fresh transaction
        if8.in_valid = 1'b1;
        if8.a        = 8'hAA;
        if8.b        = 8'h55;
        if8.bin      = 1'b0;
        tick();
        if8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_val("mid_busy_before", 32'(if8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy",      32'(if8.busy),      32'd0);
        check_val("mid_rst_out_valid", 32'(if8.out_valid), 32'd0);
        check_val("mid_rst_diff",      32'(if8.diff),      32'd0);
        check_val("mid_rst_bout",      32'(if8.bout),      32'd0);
        check_val("mid_rst_in_ready",  32'(if8.in_ready),  32'd0);
        #10;
        rst_n = 1'b1;
        txn8("after_rst", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1);

        // ---------------- exhaustive sweep (WIDTH=4, BPC=2)
        for (int x = 0; x < 512; x++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ebin;
            logic [4:0] m;
            int         stall;
            int         n;
            int         lat;
            bit         seen;
            ea   = x[3:0];
            eb   = x[7:4];
            ebin = x[8];
            m    = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
            stall = int'($urandom_range(0, 2));
            if4.out_ready = (stall == 0);
            n = 0;
            while (!if4.in_ready && n < 20) begin
                tick();
                n++;
            end
            if (!if4.in_ready) check_val("ex_in_ready", 32'(if4.in_ready), 32'd1);
            if4.in_valid = 1'b1;
            if4.a        = ea;
            if4.b        = eb;
            if4.bin      = ebin;
            tick();
            if4.in_valid = 1'b0;
            if4.a        = ~ea;
            if4.b        = ~eb;
            if4.bin      = ~ebin;
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 20) begin
                tick();
                lat++;
                seen = if4.out_valid;
            end
            check_val("ex_latency", 32'(lat), 32'd2);
            check_val("ex_diff", 32'(if4.diff), 32'(m[3:0]));
            check_val("ex_bout", 32'(if4.bout), 32'(m[4]));
            for (int k = 0; k < stall; k++) begin
                tick();
            end
            if (stall > 0) begin
                check_val("ex_stall_diff", 32'(if4.diff), 32'(m[3:0]));
            end
            if4.out_ready = 1'b1;
            tick();
            check_val("ex_valid_drop", 32'(if4.out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
